axis_frame_gen: RTL and testbench

- AXI-stream frame transmitter that drives test and bring-up traffic into stream sinks such as the packet FIFO.
- Generates a programmed number of frames of programmed byte length, with a deterministic byte pattern, tlast and last-beat tkeep.
- Honours full AXI-stream backpressure.
- Supports frame-boundary pause and stop, plus frame/beat statistics for bench and on-chip self-test.

---
 rtl/axis_full_if.sv | 21 ++
 rtl/axis_frame_gen.sv | 205 ++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_full_if.sv
// AXI-stream bundle with every optional sideband (tkeep, tlast, tid, tdest, tuser).
// The 'out' modport drives a stream and the 'in' modport receives one.
interface axis_full_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int DST_W  = 8,
  parameter int USR_W  = 1
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DST_W-1:0]  tdest;
  logic [USR_W-1:0]  tuser;

  modport out (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport in  (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI-stream frame generator: programmed frame count and length, deterministic byte pattern,
// full backpressure, and pause/stop that only take effect at frame boundaries.
module axis_frame_gen #(
  parameter int DATA_W     = 8,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int ID_W       = 8,
  parameter int DST_W      = 8,
  parameter int USR_W      = 1,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             srst_n,
  axis_full_if.out         m_axis,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [CNT_W-1:0] frame_count,
  input  logic [7:0]       seed,
  input  logic [ID_W-1:0]  tid_in,
  input  logic [DST_W-1:0] tdest_in,
  input  logic             pause_req,
  output logic             pause_ack,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_beats
);
  localparam int BEAT_W = LEN_W + 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, PAUSE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USR_W-1:0]  user;
  } beat_t;

  // Keep mask for the final beat: low (len mod KEEP_W) lanes, or all lanes when it divides evenly.
  function automatic logic [KEEP_W-1:0] tail_keep(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] rem;
    tail_keep = '1;
    rem = len % LEN_W'(KEEP_W);
    if (rem != '0)
      for (int k = 0; k < KEEP_W; k++) tail_keep[k] = (LEN_W'(k) < rem);
  endfunction

  function automatic beat_t make_beat(input logic [7:0] s, input logic [BEAT_W-1:0] b,
                                      input logic [BEAT_W-1:0] n, input logic [KEEP_W-1:0] lk);
    beat_t      r;
    logic [7:0] base;
    base    = s + 8'(b * BEAT_W'(KEEP_W));
    r.last  = (b == n - BEAT_W'(1));
    r.keep  = r.last ? lk : '1;
    r.user  = '0;
    r.user[0] = (b == '0);
    for (int k = 0; k < KEEP_W; k++)
      r.data[8*k +: 8] = r.keep[k] ? base + 8'(k) : 8'h00;
    return r;
  endfunction

  state_t            state;
  beat_t             pay;
  logic              tvalid_q;
  logic [BEAT_W-1:0] beat_idx, beats_q;
  logic [KEEP_W-1:0] keep_q;
  logic [7:0]        seed_q;
  logic [ID_W-1:0]   tid_q;
  logic [DST_W-1:0]  tdest_q;
  logic              cont_q;
  logic [CNT_W-1:0]  frames_left;
  logic [GAP_W-1:0]  gap_cnt;

  logic [BEAT_W-1:0] new_beats;
  logic [KEEP_W-1:0] new_keep;
  beat_t             first_beat, next_beat;
  logic              hs, last_frame;

  assign new_beats  = (BEAT_W'(frame_len) + BEAT_W'(KEEP_W - 1)) / BEAT_W'(KEEP_W);
  assign new_keep   = tail_keep(frame_len);
  assign first_beat = make_beat(seed_q, '0, beats_q, keep_q);
  assign next_beat  = make_beat(seed_q, beat_idx + BEAT_W'(1), beats_q, keep_q);
  assign hs         = tvalid_q & m_axis.tready;
  assign last_frame = !cont_q && (frames_left == CNT_W'(1));

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = pay.data;
  assign m_axis.tkeep  = pay.keep;
  assign m_axis.tlast  = pay.last;
  assign m_axis.tuser  = pay.user;
  assign m_axis.tid    = tid_q;
  assign m_axis.tdest  = tdest_q;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state       <= IDLE;
      pay         <= '0;
      tvalid_q    <= 1'b0;
      beat_idx    <= '0;
      beats_q     <= '0;
      keep_q      <= '0;
      seed_q      <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      cont_q      <= 1'b0;
      frames_left <= '0;
      gap_cnt     <= '0;
      pause_ack   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      stat_frames <= '0;
      stat_beats  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          if (frame_len == '0) begin
            cfg_err <= 1'b1;
          end else begin
            state       <= SEND;
            busy        <= 1'b1;
            tvalid_q    <= 1'b1;
            pay         <= make_beat(seed, '0, new_beats, new_keep);
            beat_idx    <= '0;
            beats_q     <= new_beats;
            keep_q      <= new_keep;
            seed_q      <= seed;
            tid_q       <= tid_in;
            tdest_q     <= tdest_in;
            cont_q      <= (frame_count == '0);
            frames_left <= frame_count;
            stat_frames <= '0;
            stat_beats  <= '0;
          end
        end
        SEND: if (hs) begin
          stat_beats <= stat_beats + CNT_W'(1);
          if (!pay.last) begin
            beat_idx <= beat_idx + BEAT_W'(1);
            pay      <= next_beat;
          end else begin
            if (stat_frames != '1) stat_frames <= stat_frames + CNT_W'(1);
            frames_left <= frames_left - CNT_W'(1);
            beat_idx    <= '0;
            // Stop outranks pause so a simultaneous request never leaves the generator parked.
            if (stop || last_frame) begin
              state    <= IDLE;
              tvalid_q <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (pause_req) begin
              state     <= PAUSE;
              tvalid_q  <= 1'b0;
              pause_ack <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state    <= GAP;
              tvalid_q <= 1'b0;
              gap_cnt  <= '0;
            end else begin
              pay <= first_beat;
            end
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if (pause_req) begin
              state     <= PAUSE;
              pause_ack <= 1'b1;
            end else begin
              state    <= SEND;
              tvalid_q <= 1'b1;
              pay      <= first_beat;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        PAUSE: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pause_ack <= 1'b0;
          end else if (!pause_req) begin
            state     <= SEND;
            pause_ack <= 1'b0;
            tvalid_q  <= 1'b1;
            pay       <= first_beat;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench: a transaction-level model predicts every cycle's outputs from the
// frame rules (byte index = beat*KEEP + lane), driven by directed and randomized runs.
module tb_axis_frame_gen;
  localparam int KW = 4;

  logic        clk = 1'b0;
  logic        srst_n = 1'b1;
  logic        start = 1'b0, stop = 1'b0, pause_req = 1'b0;
  logic [15:0] frame_len = '0, frame_count = '0;
  logic [7:0]  seed = '0, tid_in = '0, tdest_in = '0;
  logic        pause_ack, busy, done, cfg_err;
  logic [15:0] stat_frames, stat_beats;

  axis_full_if #(.DATA_W(32), .KEEP_W(KW), .ID_W(8), .DST_W(8), .USR_W(1)) m_axis ();

  axis_frame_gen #(.DATA_W(32), .KEEP_W(KW), .ID_W(8), .DST_W(8), .USR_W(1),
                   .LEN_W(16), .CNT_W(16), .GAP_CYCLES(0)) dut (
    .clk(clk), .srst_n(srst_n), .m_axis(m_axis),
    .start(start), .stop(stop), .frame_len(frame_len), .frame_count(frame_count),
    .seed(seed), .tid_in(tid_in), .tdest_in(tdest_in), .pause_req(pause_req),
    .pause_ack(pause_ack), .busy(busy), .done(done), .cfg_err(cfg_err),
    .stat_frames(stat_frames), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame rules in byte terms: byte i of a frame is (seed + i) mod 256, for i < len.
  function automatic logic [31:0] exp_data(input int len, input int sd, input int b);
    logic [31:0] d = '0;
    for (int k = 0; k < KW; k++)
      if (b * KW + k < len) d[8*k +: 8] = 8'((sd + b * KW + k) % 256);
    return d;
  endfunction

  function automatic logic [3:0] exp_keep(input int len, input int b);
    logic [3:0] m = '0;
    for (int k = 0; k < KW; k++) m[k] = (b * KW + k < len);
    return m;
  endfunction

  function automatic bit exp_last(input int len, input int b);
    return (b + 1) * KW >= len;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } obs_t;

  bit          m_busy, m_paused, m_done, m_cfg_err, m_nd, m_nc;
  int          m_len, m_seed, m_count, m_b, m_fdone;
  logic [7:0]  m_tid, m_tdest;
  int unsigned m_frames, m_beats;
  bit          ready_rand = 1'b0;
  obs_t        log_q[$];
  int          cyc_n = 0, valid_cycles, cfg_err_pulses, last_hs_cyc, done_cyc;
  bit          saw_ack;

  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_axis.tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    if (!srst_n) begin
      m_busy = 0; m_paused = 0; m_done = 0; m_cfg_err = 0; m_b = 0; m_fdone = 0;
      m_frames = 0; m_beats = 0;
      check("rst_tvalid", m_axis.tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pause_ack", pause_ack, 0);
      check("rst_stats", {stat_frames, stat_beats}, 0);
      check("rst_payload", {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser}, 0);
    end else begin
      check("tvalid", m_axis.tvalid, m_busy && !m_paused);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("cfg_err", cfg_err, m_cfg_err);
      check("pause_ack", pause_ack, m_paused);
      check("stat_frames", stat_frames, (m_frames > 65535) ? 65535 : m_frames);
      check("stat_beats", stat_beats, m_beats % 65536);
      if (m_busy && !m_paused) begin
        check("tdata", m_axis.tdata, exp_data(m_len, m_seed, m_b));
        check("tkeep", m_axis.tkeep, exp_keep(m_len, m_b));
        check("tlast", m_axis.tlast, exp_last(m_len, m_b));
        check("tuser", m_axis.tuser, m_b == 0);
        check("tid_tdest", {m_axis.tid, m_axis.tdest}, {m_tid, m_tdest});
        valid_cycles++;
      end
      if (cfg_err) cfg_err_pulses++;
      if (pause_ack) saw_ack = 1;
      if (done) done_cyc = cyc_n;

      m_nd = 0; m_nc = 0;
      if (!m_busy) begin
        if (start) begin
          if (frame_len == 0) m_nc = 1;
          else begin
            m_busy = 1; m_paused = 0; m_b = 0; m_fdone = 0; m_frames = 0; m_beats = 0;
            m_len = frame_len; m_seed = seed; m_count = frame_count;
            m_tid = tid_in; m_tdest = tdest_in;
          end
        end
      end else if (m_paused) begin
        if (stop) begin m_busy = 0; m_paused = 0; m_nd = 1; end
        else if (!pause_req) m_paused = 0;
      end else if (m_axis.tready) begin
        log_q.push_back('{m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser[0]});
        m_beats++;
        if (exp_last(m_len, m_b)) begin
          m_frames++; m_fdone++; m_b = 0; last_hs_cyc = cyc_n;
          if (stop || (m_count != 0 && m_fdone == m_count)) begin m_busy = 0; m_nd = 1; end
          else if (pause_req) m_paused = 1;
        end else m_b++;
      end
      m_done = m_nd;
      m_cfg_err = m_nc;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    log_q.delete();
    valid_cycles = 0; cfg_err_pulses = 0; saw_ack = 0; last_hs_cyc = -1; done_cyc = -100;
  endtask

  task automatic start_run(input int len, input int cnt, input int sd);
    frame_len = 16'(len); frame_count = 16'(cnt); seed = 8'(sd);
    tid_in = 8'($urandom); tdest_in = 8'($urandom);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_busy && n < 600) begin cyc(); n++; end
    if (n >= 600) begin
      tests++; fails++;
      $display("FAIL %s: run still busy after %0d cycles", name, n);
    end
    repeat (2) cyc();
  endtask

  task automatic wait_beat(input string name, input int frames, input int b);
    int n = 0;
    while (!(m_fdone == frames && m_b == b) && n < 300) begin cyc(); n++; end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL %s: frame %0d beat %0d never reached", name, frames, b);
    end
  endtask

  initial begin
    #1 srst_n = 1'b0;
    repeat (3) cyc();
    srst_n = 1'b1;
    cyc();

    // Directed run: 10-byte frames on a 4-byte bus.
    clear_obs();
    start_run(10, 2, 'h10);
    wait_idle("run1");
    check("run1_beats_logged", log_q.size(), 6);
    check("run1_b0_data", log_q[0].d, 32'h13121110);
    check("run1_keep_seq", {log_q[0].k, log_q[1].k, log_q[2].k}, 12'hFF3);
    check("run1_b2_data", log_q[2].d, 32'h00001918);
    check("run1_f2_restart", log_q[3].d, 32'h13121110);
    check("run1_sof", {log_q[0].u, log_q[1].u, log_q[3].u}, 3'b101);
    check("run1_valid_cycles", valid_cycles, 6);
    check("run1_done_latency", done_cyc - last_hs_cyc, 1);
    check("run1_stat_frames", stat_frames, 2);
    check("run1_stat_beats", stat_beats, 6);

    // Same run under random backpressure, with a start that must be ignored mid-run.
    clear_obs();
    ready_rand = 1'b1;
    start_run(10, 2, 'h10);
    repeat (3) cyc();
    start_run(7, 5, 'h00);
    wait_idle("run2");
    ready_rand = 1'b0;
    check("run2_beats_logged", log_q.size(), 6);
    check("run2_b0_data", log_q[0].d, 32'h13121110);
    check("run2_last_keep", log_q[5].k, 4'h3);

    // Continuous run stopped in the middle of frame 3.
    clear_obs();
    start_run(10, 0, 'h20);
    wait_beat("run3", 2, 1);
    stop = 1'b1;
    wait_idle("run3");
    stop = 1'b0;
    check("run3_stat_frames", stat_frames, 3);
    check("run3_beats_logged", log_q.size(), 9);

    // Pause requested mid-frame 1 of 3.
    clear_obs();
    start_run(10, 3, 'h40);
    wait_beat("run4", 0, 1);
    pause_req = 1'b1;
    repeat (5) cyc();
    pause_req = 1'b0;
    wait_idle("run4");
    check("run4_saw_ack", saw_ack, 1);
    check("run4_stat_frames", stat_frames, 3);
    check("run4_f2_data", log_q[3].d, 32'h43424140);

    // Zero-length start is rejected.
    clear_obs();
    start_run(0, 1, 'h55);
    repeat (3) cyc();
    check("run5_cfg_err_pulses", cfg_err_pulses, 1);
    check("run5_no_beats", log_q.size(), 0);

    // Stop and pause together at a boundary: stop wins.
    clear_obs();
    start_run(6, 0, 'h07);
    wait_beat("run6", 0, 1);
    stop = 1'b1; pause_req = 1'b1;
    wait_idle("run6");
    stop = 1'b0; pause_req = 1'b0;
    check("run6_no_ack", saw_ack, 0);
    check("run6_stat_frames", stat_frames, 1);

    // Asynchronous reset mid-frame, then a clean restart.
    start_run(12, 4, 'h80);
    repeat (2) cyc();
    check("run7_pre_rst_valid", m_axis.tvalid, 1);
    srst_n = 1'b0;
    #1;
    check("run7_async_tvalid", m_axis.tvalid, 0);
    check("run7_async_busy", busy, 0);
    repeat (2) cyc();
    srst_n = 1'b1;
    cyc();
    clear_obs();
    start_run(12, 1, 'h80);
    wait_idle("run7");
    check("run7_restart_b0", {log_q[0].d, log_q[0].u}, {32'h83828180, 1'b1});

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      clear_obs();
      ready_rand = 1'($urandom_range(0, 1));
      start_run($urandom_range(1, 21), $urandom_range(1, 3), $urandom_range(0, 255));
      wait_idle("rand_run");
    end
    ready_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
